// File: rtl/core_pkg.sv
// Shared definitions for the core slice.
// Holds the interrupt controller state encoding, its register map and its
// source-count limit.
package core_pkg;

  // The STATUS register reports the state using this encoding.
  typedef enum logic [1:0] {
    INTC_IDLE    = 2'd0,
    INTC_REQ     = 2'd1,
    INTC_SERVICE = 2'd2
  } intc_state_t;

  // Register map of the interrupt controller configuration port.
  localparam logic [1:0] INTC_REG_ENABLE  = 2'd0;
  localparam logic [1:0] INTC_REG_EDGE    = 2'd1;
  localparam logic [1:0] INTC_REG_PENDING = 2'd2;
  localparam logic [1:0] INTC_REG_STATUS  = 2'd3;

  // Largest source count that fits the 32-bit register port.
  localparam int INTC_MAX_IRQ = 32;

endpackage

// File: rtl/core_intc_prio.sv
// Fixed-priority encoder for the interrupt controller.
// Index 0 has the highest priority.
// Ports:
//   i_req_vec  in   N     request vector
//   o_valid    out  1     at least one request is set
//   o_id       out  ID_W  index of the lowest set bit (0 when none is set)
// The module is purely combinational.
module core_intc_prio #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    i_req_vec,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  always_comb begin
    o_valid = |i_req_vec;
    o_id    = '0;
    // Scan from the top down so that the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req_vec[i]) begin
        o_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/core_intc.sv
// Interrupt controller in front of the core exception unit.
// It samples NUM_IRQ sources, either edge-triggered or level-following.
// It arbitrates the sources by fixed priority, with index 0 highest.
// It raises irq toward the core, completes the request on irq_ack and then
// waits for the software eoi before it arbitrates again.
// Ports:
//   clk        in   1        clock
//   rst        in   1        asynchronous, active-low reset
//   irq_src    in   NUM_IRQ  source lines, synchronous to clk
//   cfg_we     in   1        register write strobe
//   cfg_addr   in   2        0=ENABLE 1=EDGE 2=PENDING(W1C) 3=STATUS(RO)
//   cfg_wdata  in   32       write data; bits at or above NUM_IRQ are ignored
//   cfg_rdata  out  32       combinational read data for cfg_addr
//   irq        out  1        registered request to the exception unit
//   irq_ack    in   1        exception unit accepted the request
//   irq_id     out  ID_W     id of the source being requested or serviced
//   eoi        in   1        end-of-interrupt pulse from software
module core_intc
  import core_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq,
  input  logic               irq_ack,
  output logic [ID_W-1:0]    irq_id,
  input  logic               eoi
);

  logic [NUM_IRQ-1:0] r_src_q;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_edge;
  intc_state_t        r_state;
  logic               r_irq;
  logic [ID_W-1:0]    r_irq_id;

  intc_state_t        w_state_next;
  logic               w_irq_next;
  logic [ID_W-1:0]    w_irq_id_next;
  logic [NUM_IRQ-1:0] w_pending_next;
  logic [NUM_IRQ-1:0] w_req_vec;
  logic               w_win_valid;
  logic [ID_W-1:0]    w_win_id;
  logic               w_wr_enable;
  logic               w_wr_edge;
  logic               w_wr_pending;
  logic               w_ack_take;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_wr_enable  = cfg_we && (cfg_addr == INTC_REG_ENABLE);
  assign w_wr_edge    = cfg_we && (cfg_addr == INTC_REG_EDGE);
  assign w_wr_pending = cfg_we && (cfg_addr == INTC_REG_PENDING);

  // An acknowledge counts only while a request is outstanding.
  assign w_ack_take = (r_state == INTC_REQ) && irq_ack;

  // The upper write-data bits have no register behind them.
  assign w_unused = &{1'b0, cfg_wdata};

  // Per-source pending update.
  // For an edge source, a new rising edge wins over both clear paths
  // (the W1C write and the acknowledge), so an event arriving in the same
  // cycle as a clear is not lost.
  // A level source simply follows its input.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
      logic w_rise;
      logic w_clr;
      assign w_rise = irq_src[gi] & ~r_src_q[gi];
      assign w_clr  = (w_wr_pending & cfg_wdata[gi]) |
                      (w_ack_take & (r_irq_id == ID_W'(gi)));
      assign w_pending_next[gi] = r_edge[gi] ? (w_rise | (r_pending[gi] & ~w_clr))
                                             : irq_src[gi];
    end
  endgenerate

  assign w_req_vec = r_pending & r_enable;

  core_intc_prio #(
    .N    (NUM_IRQ),
    .ID_W (ID_W)
  ) u_prio (
    .i_req_vec (w_req_vec),
    .o_valid   (w_win_valid),
    .o_id      (w_win_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src_q   <= '0;
      r_pending <= '0;
      r_enable  <= '0;
      r_edge    <= '0;
    end else begin
      r_src_q   <= irq_src;
      r_pending <= w_pending_next;
      if (w_wr_enable) begin
        r_enable <= cfg_wdata[NUM_IRQ-1:0];
      end
      if (w_wr_edge) begin
        r_edge <= cfg_wdata[NUM_IRQ-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= INTC_IDLE;
      r_irq    <= 1'b0;
      r_irq_id <= '0;
    end else begin
      r_state  <= w_state_next;
      r_irq    <= w_irq_next;
      r_irq_id <= w_irq_id_next;
    end
  end

  // The id is latched only when the controller leaves IDLE.
  // It stays frozen through REQ and SERVICE, so software always sees the
  // source that was granted, even if that source has since dropped.
  // An eoi that arrives together with the ack in REQ is ignored, because
  // REQ looks only at the ack.
  always_comb begin
    w_state_next  = r_state;
    w_irq_next    = r_irq;
    w_irq_id_next = r_irq_id;
    case (r_state)
      INTC_IDLE: begin
        if (w_win_valid) begin
          w_state_next  = INTC_REQ;
          w_irq_next    = 1'b1;
          w_irq_id_next = w_win_id;
        end
      end
      INTC_REQ: begin
        if (irq_ack) begin
          w_state_next = INTC_SERVICE;
          w_irq_next   = 1'b0;
        end
      end
      INTC_SERVICE: begin
        if (eoi) begin
          w_state_next = INTC_IDLE;
        end
      end
      default: begin
        w_state_next = INTC_IDLE;
        w_irq_next   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (cfg_addr)
      INTC_REG_ENABLE:  w_rdata[NUM_IRQ-1:0] = r_enable;
      INTC_REG_EDGE:    w_rdata[NUM_IRQ-1:0] = r_edge;
      INTC_REG_PENDING: w_rdata[NUM_IRQ-1:0] = r_pending;
      INTC_REG_STATUS: begin
        w_rdata[1:0]      = r_state;
        w_rdata[8 +: ID_W] = r_irq_id;
        w_rdata[31]       = |w_req_vec;
      end
      default: w_rdata = '0;
    endcase
  end

  assign cfg_rdata = w_rdata;
  assign irq       = r_irq;
  assign irq_id    = r_irq_id;

endmodule

// File: tb/tb_core_intc.sv
module tb_core_intc;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq;
  logic        irq_ack;
  logic [2:0]  irq_id;
  logic        eoi;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: register contents and the request/service phase.
  // The phase is encoded 0=idle, 1=requesting, 2=servicing.
  logic [7:0] m_srcq, m_pend, m_en, m_edge;
  logic [1:0] m_state;
  logic       m_irq;
  logic [2:0] m_id;

  always #5 clk = ~clk;

  core_intc #(.NUM_IRQ(8), .ID_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .irq_id    (irq_id),
    .eoi       (eoi)
  );

  // Advance the reference by one clock using the inputs applied for this cycle.
  task automatic m_step();
    logic [7:0] req, np;
    int win;
    if (!rst) begin
      m_srcq = 0; m_pend = 0; m_en = 0; m_edge = 0;
      m_state = 0; m_irq = 0; m_id = 0;
      return;
    end
    req = m_pend & m_en;
    win = -1;
    for (int i = 7; i >= 0; i--) if (req[i]) win = i;
    for (int i = 0; i < 8; i++) begin
      if (m_edge[i]) begin
        if (irq_src[i] && !m_srcq[i]) np[i] = 1'b1;
        else if ((cfg_we && cfg_addr == 2 && cfg_wdata[i]) ||
                 (m_state == 1 && irq_ack && int'(m_id) == i)) np[i] = 1'b0;
        else np[i] = m_pend[i];
      end else begin
        np[i] = irq_src[i];
      end
    end
    if (m_state == 0 && win >= 0) begin
      m_state = 1; m_irq = 1; m_id = 3'(win);
    end else if (m_state == 1 && irq_ack) begin
      m_state = 2; m_irq = 0;
    end else if (m_state == 2 && eoi) begin
      m_state = 0;
    end
    if (cfg_we && cfg_addr == 0) m_en = cfg_wdata[7:0];
    if (cfg_we && cfg_addr == 1) m_edge = cfg_wdata[7:0];
    m_srcq = irq_src;
    m_pend = np;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic apply_reset();
    rst = 0; irq_src = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    irq_ack = 0; eoi = 0;
    tick(); tick();
    rst = 1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 0; irq_src = 8'hFF; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    irq_ack = 0; eoi = 0;
    tick();
    rd(2, d);
    checks++;
    if (irq !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: irq=%b pending=%h, required irq=0 pending=0", irq, d);
    end
    rst = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      rd(2, d);
      checks++;
      if (irq !== 1'b0 || d !== 32'h0000_00FF) begin
        errors++;
        $display("FAIL reset_level c%0d: irq=%b pending=%h, required irq=0 pending=ff", c, irq, d);
      end
      rd(3, d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_status c%0d: status=%h, required 0", c, d);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_edge_prio();
    logic [31:0] d;
    apply_reset();
    wr(0, 32'h0C);
    wr(1, 32'h0C);
    irq_src = 8'h0C;
    tick();
    irq_src = 0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL edge_lat1: irq=%b, required 0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 3'd2) begin
      errors++; $display("FAIL edge_first: irq=%b id=%0d, required irq=1 id=2", irq, irq_id);
    end
    irq_ack = 1; tick(); irq_ack = 0;
    rd(3, d);
    checks++;
    if (irq !== 1'b0 || d[1:0] !== 2'd2) begin
      errors++; $display("FAIL edge_ack: irq=%b state=%0d, required irq=0 state=2", irq, d[1:0]);
    end
    rd(2, d);
    checks++;
    if (d !== 32'h08) begin
      errors++; $display("FAIL edge_ackclr: pending=%h, required 08", d);
    end
    eoi = 1; tick(); eoi = 0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL edge_eoi: irq=%b, required 0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 3'd3) begin
      errors++; $display("FAIL edge_second: irq=%b id=%0d, required irq=1 id=3", irq, irq_id);
    end
    $display("test_edge_prio done");
  endtask

  task automatic test_level_drop();
    logic [31:0] d;
    apply_reset();
    irq_src = 8'h20;
    wr(0, 32'h20);
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 3'd5) begin
      errors++; $display("FAIL level_req: irq=%b id=%0d, required irq=1 id=5", irq, irq_id);
    end
    irq_src = 0;
    tick(); tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 3'd5) begin
      errors++; $display("FAIL level_hold: irq=%b id=%0d, required irq=1 id=5", irq, irq_id);
    end
    irq_ack = 1; tick(); irq_ack = 0;
    tick(); tick();
    rd(3, d);
    checks++;
    if (irq !== 1'b0 || d[1:0] !== 2'd2 || d[10:8] !== 3'd5) begin
      errors++; $display("FAIL level_service: irq=%b status=%h, required irq=0 state=2 id=5", irq, d);
    end
    eoi = 1; tick(); eoi = 0;
    tick();
    rd(3, d);
    checks++;
    if (irq !== 1'b0 || d[1:0] !== 2'd0) begin
      errors++; $display("FAIL level_idle: irq=%b state=%0d, required irq=0 state=0", irq, d[1:0]);
    end
    $display("test_level_drop done");
  endtask

  task automatic test_no_nesting();
    apply_reset();
    irq_src = 8'h40;
    wr(0, 32'h41);
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 3'd6) begin
      errors++; $display("FAIL nest_req: irq=%b id=%0d, required irq=1 id=6", irq, irq_id);
    end
    irq_ack = 1; tick(); irq_ack = 0;
    irq_src = 8'h41;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (irq !== 1'b0) begin
        errors++; $display("FAIL nest_blocked c%0d: irq=%b, required 0", c, irq);
      end
    end
    eoi = 1; tick(); eoi = 0;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL nest_eoi: irq=%b, required 0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 3'd0) begin
      errors++; $display("FAIL nest_b2b: irq=%b id=%0d, required irq=1 id=0", irq, irq_id);
    end
    $display("test_no_nesting done");
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    apply_reset();
    wr(1, 32'h02);
    irq_src = 8'h02; tick();
    irq_src = 0; tick();
    rd(2, d);
    checks++;
    if (d !== 32'h02) begin
      errors++; $display("FAIL w1c_set: pending=%h, required 02", d);
    end
    irq_src = 8'h02;
    cfg_we = 1; cfg_addr = 2; cfg_wdata = 32'h02;
    tick();
    cfg_we = 0; irq_src = 0;
    rd(2, d);
    checks++;
    if (d !== 32'h02) begin
      errors++; $display("FAIL w1c_race: pending=%h, required 02", d);
    end
    wr(2, 32'h02);
    rd(2, d);
    checks++;
    if (d !== 32'h00) begin
      errors++; $display("FAIL w1c_clear: pending=%h, required 00", d);
    end
    $display("test_w1c_race done");
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    apply_reset();
    irq_src = 8'h10;
    wr(0, 32'h10);
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 3'd4) begin
      errors++; $display("FAIL areset_req: irq=%b id=%0d, required irq=1 id=4", irq, irq_id);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL areset_drop: irq=%b, required 0 before next edge", irq);
    end
    tick();
    rst = 1; irq_src = 0;
    rd(0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL areset_enable: enable=%h, required 0", d);
    end
    rd(3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL areset_status: status=%h, required 0", d);
    end
    wr(1, 32'h01);
    irq_src = 8'h01; tick();
    irq_src = 0; tick();
    irq_ack = 1; eoi = 1; tick(); irq_ack = 0; eoi = 0;
    rd(2, d);
    checks++;
    if (d !== 32'h01) begin
      errors++; $display("FAIL stray_pending: pending=%h, required 01", d);
    end
    rd(3, d);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL stray_state: status=%h irq=%b, required 0 and 0", d, irq);
    end
    wr(0, 32'h01);
    tick();
    checks++;
    if (irq !== 1'b1 || irq_id !== 3'd0) begin
      errors++; $display("FAIL stray_after: irq=%b id=%0d, required irq=1 id=0", irq, irq_id);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [31:0] d, exp_st;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      irq_src   = 8'($urandom);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = $urandom;
      irq_ack   = ($urandom_range(0, 2) == 0);
      eoi       = ($urandom_range(0, 3) == 0);
      tick();
      cfg_we = 0; irq_ack = 0; eoi = 0;
      checks++;
      if (irq !== m_irq || irq_id !== m_id) begin
        errors++;
        $display("FAIL rand_irq c%0d: irq=%b id=%0d, required irq=%b id=%0d", c, irq, irq_id, m_irq, m_id);
      end
      rd(2, d);
      checks++;
      if (d !== {24'h0, m_pend}) begin
        errors++; $display("FAIL rand_pending c%0d: pending=%h, required %h", c, d, m_pend);
      end
      exp_st = 0;
      exp_st[1:0]  = m_state;
      exp_st[10:8] = m_id;
      exp_st[31]   = |(m_pend & m_en);
      rd(3, d);
      checks++;
      if (d !== exp_st) begin
        errors++; $display("FAIL rand_status c%0d: status=%h, required %h", c, d, exp_st);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_edge_prio();
    test_level_drop();
    test_no_nesting();
    test_w1c_race();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
